gshare_local_predictor: RTL



---
 rtl/gshare_local_predictor_pkg.sv | 25 ++
 rtl/gshare_local_predictor_if.sv | 24 ++
 rtl/gshare_local_predictor_init_sweeper.sv | 51 +++++
 rtl/gshare_local_predictor.sv | 123 ++++++++++++
 4 files changed

// File: rtl/gshare_local_predictor_pkg.sv
// Shared types and helper functions for the gshare/local branch predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pred_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} pred_state_e;

  typedef enum logic {HASH_CONCAT = 1'b0, HASH_XOR = 1'b1} hash_mode_e;

  // Next value of a ctr_bits-wide saturating counter (carried in 32 bits).
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic taken,
                                               input int unsigned ctr_bits);
    logic [31:0] max_v;
    max_v = (ctr_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ctr_bits) - 32'd1);
    if (taken) return (ctr == max_v) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

  // Weakly-taken encoding: only the MSB set.
  function automatic logic [31:0] wt_value(input int unsigned ctr_bits);
    return 32'd1 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/gshare_local_predictor_if.sv
// Fetch-side predict port plus resolve-side update port and status outputs.
// Latency: n/a (signal bundle).
// Backpressure: none; update strobe is always accepted once tables are ready.
interface gshare_local_predictor_if;
  logic [31:0] read_pc;
  logic        prediction;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_correct;
  logic        ready;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  modport master (
    output read_pc, upd_valid, upd_pc, upd_taken,
    input  prediction, upd_correct, ready, stat_updates, stat_mispredicts
  );

  modport slave (
    input  read_pc, upd_valid, upd_pc, upd_taken,
    output prediction, upd_correct, ready, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/gshare_local_predictor_init_sweeper.sv
// INIT/RUN sequencer: walks every table address once after reset, then flags ready.
// Latency: 2^SWEEP_BITS cycles from reset release to ready.
// Backpressure: none; reset at any point restarts the walk at address 0.
module pred_init_sweeper
  import pred_pkg::*;
#(
  parameter int unsigned SWEEP_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [SWEEP_BITS-1:0] sweep_addr_o,
  output logic                  sweeping_o,
  output logic                  ready_o
);

  localparam logic [SWEEP_BITS-1:0] LAST_ADDR = '1;

  pred_state_e           state_q, state_d;
  logic [SWEEP_BITS-1:0] addr_q, addr_d;

  // State and sweep address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: advance the address every INIT cycle, leave INIT after the last one
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sweeping_o = 1'b0;
    ready_o    = 1'b0;
    case (state_q)
      INIT: begin
        sweeping_o = 1'b1;
        addr_d     = addr_q + SWEEP_BITS'(1);
        if (addr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: ready_o = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign sweep_addr_o = addr_q;

endmodule

// File: rtl/gshare_local_predictor.sv
// Two-level branch predictor: GHR + per-PC local history index a table of saturating counters.
// Latency: prediction combinational (0 cycles); updates visible the cycle after upd_valid.
// Backpressure: none; updates ignored while the post-reset sweep runs. Optional stats: PRED_STATS_EN.
module gshare_local_predictor
  import pred_pkg::*;
#(
  parameter int unsigned PHT_IDX_BITS = 10,
  parameter int unsigned LHT_IDX_BITS = 8,
  parameter int unsigned GHR_BITS     = 4,
  parameter int unsigned LH_BITS      = 2,
  parameter int unsigned CTR_BITS     = 2,
  parameter hash_mode_e  HASH_MODE    = HASH_XOR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gshare_local_predictor_if.slave  bus
);

  localparam int unsigned SWEEP_BITS = (PHT_IDX_BITS > LHT_IDX_BITS) ? PHT_IDX_BITS : LHT_IDX_BITS;
  localparam int unsigned PHT_DEPTH  = 1 << PHT_IDX_BITS;
  localparam int unsigned LHT_DEPTH  = 1 << LHT_IDX_BITS;
  localparam logic [SWEEP_BITS:0] PHT_END = (SWEEP_BITS+1)'(PHT_DEPTH);
  localparam logic [SWEEP_BITS:0] LHT_END = (SWEEP_BITS+1)'(LHT_DEPTH);
  localparam logic [CTR_BITS-1:0] WT = CTR_BITS'(wt_value(CTR_BITS));

  if (GHR_BITS + LH_BITS > PHT_IDX_BITS) begin : g_bad_hist
    $error("GHR_BITS+LH_BITS must not exceed PHT_IDX_BITS");
  end
  if (CTR_BITS < 2) begin : g_bad_ctr
    $error("CTR_BITS must be at least 2");
  end

  logic [CTR_BITS-1:0] pht_q [PHT_DEPTH];
  logic [LH_BITS-1:0]  lht_q [LHT_DEPTH];
  logic [GHR_BITS-1:0] ghr_q;

  logic [SWEEP_BITS-1:0] sweep_addr;
  logic                  sweeping;
  logic                  run;

  pred_init_sweeper #(.SWEEP_BITS(SWEEP_BITS)) u_sweeper (
    .clk         (clk),
    .rst_n       (rst_n),
    .sweep_addr_o(sweep_addr),
    .sweeping_o  (sweeping),
    .ready_o     (run)
  );

  // Concatenate keeps low PC bits above the history; XOR folds history into the PC bits.
  function automatic logic [PHT_IDX_BITS-1:0] pht_index(input logic [PHT_IDX_BITS-1:0] base,
                                                         input logic [GHR_BITS-1:0] g,
                                                         input logic [LH_BITS-1:0] lh);
    logic [PHT_IDX_BITS-1:0] h;
    h = PHT_IDX_BITS'({g, lh});
    if (HASH_MODE == HASH_XOR) return base ^ h;
    return (base << (GHR_BITS + LH_BITS)) | h;
  endfunction

  logic [LHT_IDX_BITS-1:0] rd_lidx, up_lidx;
  logic [LH_BITS-1:0]      rd_lh, up_lh, up_lh_next;
  logic [PHT_IDX_BITS-1:0] rd_idx, up_idx;
  logic [CTR_BITS-1:0]     up_ctr, up_ctr_next;
  logic [GHR_BITS-1:0]     ghr_next;
  logic                    upd_fire;
  logic                    unused_pc_bits;

  assign rd_lidx = bus.read_pc[LHT_IDX_BITS+1:2];
  assign up_lidx = bus.upd_pc[LHT_IDX_BITS+1:2];
  assign rd_lh   = lht_q[rd_lidx];
  assign up_lh   = lht_q[up_lidx];
  assign rd_idx  = pht_index(bus.read_pc[PHT_IDX_BITS+1:2], ghr_q, rd_lh);
  assign up_idx  = pht_index(bus.upd_pc[PHT_IDX_BITS+1:2], ghr_q, up_lh);
  assign up_ctr  = pht_q[up_idx];

  assign up_ctr_next = CTR_BITS'(sat_ctr_next(32'(up_ctr), bus.upd_taken, CTR_BITS));
  assign up_lh_next  = LH_BITS'({bus.upd_taken, up_lh} >> 1);
  assign ghr_next    = GHR_BITS'({bus.upd_taken, ghr_q} >> 1);
  assign upd_fire    = run & bus.upd_valid;

  assign bus.prediction  = sweeping ? 1'b1 : pht_q[rd_idx][CTR_BITS-1];
  assign bus.upd_correct = run & (up_ctr[CTR_BITS-1] == bus.upd_taken);
  assign bus.ready       = run;
  assign unused_pc_bits  = ^{bus.read_pc, bus.upd_pc};

  // Table writes: sweep initialisation in INIT, trained update in RUN
  always_ff @(posedge clk) begin
    if (sweeping) begin
      if ({1'b0, sweep_addr} < PHT_END) pht_q[sweep_addr[PHT_IDX_BITS-1:0]] <= WT;
      if ({1'b0, sweep_addr} < LHT_END) lht_q[sweep_addr[LHT_IDX_BITS-1:0]] <= '0;
    end else if (upd_fire) begin
      pht_q[up_idx]  <= up_ctr_next;
      lht_q[up_lidx] <= up_lh_next;
    end
  end

  // Global history shifts in the newest outcome at the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else if (upd_fire) ghr_q <= ghr_next;
  end

`ifdef PRED_STATS_EN
  logic [31:0] stat_upd_q, stat_mis_q;

  // Saturating update / mispredict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (upd_fire) begin
      if (stat_upd_q != 32'hFFFF_FFFF) stat_upd_q <= stat_upd_q + 32'd1;
      if (!bus.upd_correct && stat_mis_q != 32'hFFFF_FFFF) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bus.stat_updates     = stat_upd_q;
  assign bus.stat_mispredicts = stat_mis_q;
`else
  assign bus.stat_updates     = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule
